// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Ceiling log2; clog2(WIDTH+1) sizes a counter that can hold WIDTH.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_bit.sv
// Single-bit combinational full-adder slice used by the serial adder.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice, LSB first, WIDTH cycles per sum.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             carry
);

  localparam int unsigned CNT_W = clog2(WIDTH + 1);

  state_t             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   work;
  logic               c_reg;
  logic [CNT_W-1:0]   cnt;
  logic               fa_s;
  logic               fa_c;
  logic [WIDTH-1:0]   b_load;
  logic               c_load;

  // Subtraction is A + ~B + 1; carry=1 then means no borrow.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~B : B;
  assign c_load = sub | Cin;
`else
  assign b_load = B;
  assign c_load = Cin;
`endif

  fa_bit u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (c_reg),
    .s    (fa_s),
    .cout (fa_c)
  );

  // Sequencing; S/carry only update on the final RUN cycle so they never show partials.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      carry <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      work  <= '0;
      c_reg <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (start) begin
            a_sr  <= A;
            b_sr  <= b_load;
            c_reg <= c_load;
            work  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          c_reg <= fa_c;
          work  <= {fa_s, work[WIDTH-1:1]};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            S     <= {fa_s, work[WIDTH-1:1]};
            carry <= fa_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8); subtract checks need SERIAL_ADDER_SUB_EN.
module tb_serial_adder_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             carry;

  int n_vec;
  int n_err;
  int cyc;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .S     (S),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation: checks busy window, done latency, result and done width.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] es, input logic ec, input string nm);
    int  lat;
    bit  busy_ok;
    A = a; B = b; Cin = ci; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 12) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      step();
      lat++;
    end
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " latency"}, 32'(lat), 32'd8);
    chk({nm, " busy window"}, 32'(busy_ok), 32'd1);
    chk({nm, " busy at done"}, 32'(busy), 32'd0);
    chk({nm, " S"}, 32'(S), 32'(es));
    chk({nm, " carry"}, 32'(carry), 32'(ec));
    step();
    chk({nm, " done one cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int  d1;
    int  d2;
    int  k;
    bit  ok;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif

    // All eight bit-0 combinations of A, B, Cin, then wider patterns
    for (int i = 0; i < 8; i++) begin
      vecs[i].a   = 8'(i & 1);
      vecs[i].b   = 8'((i >> 1) & 1);
      vecs[i].cin = 1'((i >> 2) & 1);
      vecs[i].s   = 8'((i & 1) + ((i >> 1) & 1) + ((i >> 2) & 1));
      vecs[i].c   = 1'b0;
    end
    vecs[8]  = '{a: 8'h0F, b: 8'h01, cin: 1'b0, s: 8'h10, c: 1'b0};
    vecs[9]  = '{a: 8'h12, b: 8'h34, cin: 1'b0, s: 8'h46, c: 1'b0};
    vecs[10] = '{a: 8'h55, b: 8'hAA, cin: 1'b0, s: 8'hFF, c: 1'b0};
    vecs[11] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, c: 1'b1};
    vecs[12] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, c: 1'b1};
    vecs[13] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, c: 1'b0};
    vecs[14] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, s: 8'h80, c: 1'b0};

    #2;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset S", 32'(S), 32'd0);
    chk("reset carry", 32'(carry), 32'd0);
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < 15; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, $sformatf("vec%0d", i));

    // Wrap with carry-in, then result must hold while idle
    run_op(8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, "wrap");
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (S !== 8'h01 || carry !== 1'b1 || busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
      step();
    end
    chk("idle hold", 32'(ok), 32'd1);

    // Start held high: second operands presented during RUN must be ignored until FIN
    A = 8'h55; B = 8'hAA; Cin = 1'b0; start = 1'b1;
    step();
    A = 8'h80; B = 8'h80;
    k = 0;
    while (!done && k < 12) begin step(); k++; end
    d1 = cyc;
    chk("b2b first done", 32'(done), 32'd1);
    chk("b2b first S", 32'(S), 32'hFF);
    chk("b2b first carry", 32'(carry), 32'd0);
    step();
    chk("b2b restart busy", 32'(busy), 32'd1);
    k = 0;
    ok = 1'b1;
    while (!done && k < 12) begin
      if (S !== 8'hFF || carry !== 1'b0) ok = 1'b0;
      step();
      k++;
    end
    d2 = cyc;
    start = 1'b0;
    chk("b2b no partial S", 32'(ok), 32'd1);
    chk("b2b second done", 32'(done), 32'd1);
    chk("b2b spacing", 32'(d2 - d1), 32'd9);
    chk("b2b second S", 32'(S), 32'h00);
    chk("b2b second carry", 32'(carry), 32'd1);
    step();
    chk("b2b fin to idle", 32'(busy), 32'd0);

    // Reset mid-RUN aborts without a done pulse
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "pre-abort");
    A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("abort pre busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort S", 32'(S), 32'd0);
    chk("abort carry", 32'(carry), 32'd0);
    step();
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done !== 1'b0 || busy !== 1'b0 || S !== 8'h00) ok = 1'b0;
      step();
    end
    chk("abort no done", 32'(ok), 32'd1);
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "post-abort");

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, "sub 10-01");
    run_op(8'h01, 8'h02, 1'b0, 8'hFF, 1'b0, "sub 01-02");
    sub = 1'b0;
    run_op(8'h10, 8'h01, 1'b0, 8'h11, 1'b0, "add after sub");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
